// File: rtl/eth_status_counters.sv
// Per-channel, per-bit event counters for Ethernet MAC/FIFO status pulses,
// with wrap or saturate limits, clear-on-read and a sticky overflow per channel.
module eth_status_counters #(
  parameter int                      CHANNELS      = 4,
  parameter int                      STATUS_WIDTH  = 16,
  parameter int                      COUNTER_WIDTH = 32,
  parameter bit                      SATURATE      = 1'b1,
  parameter logic [STATUS_WIDTH-1:0] COUNT_MASK    = 16'h01FF,
  localparam int                     CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int                     IDX_W = (STATUS_WIDTH > 1) ? $clog2(STATUS_WIDTH) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [CHANNELS*STATUS_WIDTH-1:0] status_in,
  input  logic                         clear_all,
  input  logic                         rd_req,
  input  logic [CH_W-1:0]              rd_channel,
  input  logic [IDX_W-1:0]             rd_index,
  input  logic                         rd_clear,
  output logic                         rd_ack,
  output logic [COUNTER_WIDTH-1:0]     rd_data,
  output logic [CHANNELS-1:0]          overflow
);

  typedef logic [COUNTER_WIDTH-1:0] cnt_t;

  cnt_t                w_cnt [CHANNELS][STATUS_WIDTH];
  logic                w_lim [CHANNELS][STATUS_WIDTH];
  logic [CHANNELS-1:0] w_ovf_set;
  logic                w_rd_valid;
  logic                w_rd_clr_hit;
  cnt_t                w_rd_sel;
  logic                w_unused_status;

  logic                r_rd_ack;
  cnt_t                r_rd_data;
  logic [CHANNELS-1:0] r_ovf;

  // Masked-off status bits feed no counter and are deliberately ignored.
  assign w_unused_status = ^status_in;

  // NOTE: every signal gets a default before any conditional assignment,
  // otherwise always_comb would infer a latch on the untaken path.
  always_comb begin
    w_rd_valid = 1'b0;
    if (int'(rd_channel) < CHANNELS && int'(rd_index) < STATUS_WIDTH)
      w_rd_valid = COUNT_MASK[rd_index];
  end

  assign w_rd_clr_hit = rd_req & rd_clear & w_rd_valid;

  always_comb begin
    w_rd_sel = '0;
    if (w_rd_valid)
      w_rd_sel = w_cnt[rd_channel][rd_index];
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    for (genvar b = 0; b < STATUS_WIDTH; b++) begin : g_bit
      if (COUNT_MASK[b]) begin : g_cnt
        cnt_t r_cnt;
        cnt_t w_base;
        cnt_t w_next;
        logic w_hit;

        // The clear is applied first so a pulse in the clearing cycle lands as 1.
        always_comb begin
          w_base = r_cnt;
          if (clear_all || (w_rd_clr_hit && int'(rd_channel) == c && int'(rd_index) == b))
            w_base = '0;
          w_next = w_base;
          w_hit  = 1'b0;
          if (status_in[c*STATUS_WIDTH+b]) begin
            if (&w_base) begin
              w_hit  = 1'b1;
              w_next = SATURATE ? w_base : '0;
            end else begin
              w_next = w_base + cnt_t'(1);
            end
          end
        end

        // NOTE: counters are individual flops, not a RAM, so they take the
        // synchronous reset like any other state; non-blocking assignment keeps
        // every flop sampling pre-edge values.
        always_ff @(posedge clk) begin
          if (rst) r_cnt <= '0;
          else     r_cnt <= w_next;
        end

        assign w_cnt[c][b] = r_cnt;
        assign w_lim[c][b] = w_hit;
      end else begin : g_off
        assign w_cnt[c][b] = '0;
        assign w_lim[c][b] = 1'b0;
      end
    end
  end

  always_comb begin
    w_ovf_set = '0;
    for (int c = 0; c < CHANNELS; c++)
      for (int b = 0; b < STATUS_WIDTH; b++)
        w_ovf_set[c] = w_ovf_set[c] | w_lim[c][b];
  end

  always_ff @(posedge clk) begin
    if (rst || clear_all) r_ovf <= '0;
    else                  r_ovf <= r_ovf | w_ovf_set;
  end

  // Read data is captured from the pre-update counter value.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ack  <= 1'b0;
      r_rd_data <= '0;
    end else begin
      r_rd_ack <= rd_req;
      if (rd_req)
        r_rd_data <= w_rd_sel;
    end
  end

  assign rd_ack   = r_rd_ack;
  assign rd_data  = r_rd_data;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_eth_status_counters.sv
// Bench for eth_status_counters: a saturating 4-channel and a wrapping 3-channel
// instance share one stimulus stream and are compared against event-count models.
module tb_eth_status_counters;

  localparam logic [15:0] MASK = 16'h01FF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] status_in = '0;
  logic        clear_all = 1'b0;
  logic        rd_req = 1'b0;
  logic [1:0]  rd_channel = '0;
  logic [3:0]  rd_index = '0;
  logic        rd_clear = 1'b0;

  logic        a_ack, b_ack;
  logic [7:0]  a_data, b_data;
  logic [3:0]  a_ovf;
  logic [2:0]  b_ovf;

  eth_status_counters #(
    .CHANNELS(4), .STATUS_WIDTH(16), .COUNTER_WIDTH(8), .SATURATE(1'b1), .COUNT_MASK(MASK)
  ) u_sat (
    .clk(clk), .rst(rst), .status_in(status_in), .clear_all(clear_all),
    .rd_req(rd_req), .rd_channel(rd_channel), .rd_index(rd_index), .rd_clear(rd_clear),
    .rd_ack(a_ack), .rd_data(a_data), .overflow(a_ovf)
  );

  eth_status_counters #(
    .CHANNELS(3), .STATUS_WIDTH(16), .COUNTER_WIDTH(8), .SATURATE(1'b0), .COUNT_MASK(MASK)
  ) u_wrap (
    .clk(clk), .rst(rst), .status_in(status_in[47:0]), .clear_all(clear_all),
    .rd_req(rd_req), .rd_channel(rd_channel), .rd_index(rd_index), .rd_clear(rd_clear),
    .rd_ack(b_ack), .rd_data(b_data), .overflow(b_ovf)
  );

  always #5 clk = ~clk;

  // Reference model: raw event totals since the last clear of each counter.
  int unsigned ev_a [4][16];
  int unsigned ev_b [3][16];
  logic [3:0]  m_ovf_a;
  logic [2:0]  m_ovf_b;
  logic        m_ack;
  logic [7:0]  m_data_a, m_data_b;

  int n_pass  = 0;
  int n_total = 0;

  function automatic logic [7:0] sat_val(input int unsigned e);
    return (e > 255) ? 8'd255 : 8'(e);
  endfunction

  function automatic logic [7:0] wrap_val(input int unsigned e);
    return 8'(e % 256);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic r, input logic [63:0] s, input logic ca, input logic rq,
                            input logic [1:0] ch, input logic [3:0] idx, input logic rc);
    logic va, vb;
    int unsigned base;
    if (r) begin
      for (int c = 0; c < 4; c++) for (int b = 0; b < 16; b++) ev_a[c][b] = 0;
      for (int c = 0; c < 3; c++) for (int b = 0; b < 16; b++) ev_b[c][b] = 0;
      m_ovf_a = '0; m_ovf_b = '0; m_ack = 1'b0; m_data_a = '0; m_data_b = '0;
      return;
    end
    va = MASK[idx];
    vb = (ch < 2'd3) && MASK[idx];
    m_ack = rq;
    if (rq) begin
      m_data_a = va ? sat_val(ev_a[ch][idx]) : 8'd0;
      m_data_b = vb ? wrap_val(ev_b[ch][idx]) : 8'd0;
    end
    if (ca) begin m_ovf_a = '0; m_ovf_b = '0; end
    for (int c = 0; c < 4; c++) begin
      for (int b = 0; b < 16; b++) begin
        if (!MASK[b]) continue;
        base = (ca || (rq && rc && va && int'(ch) == c && int'(idx) == b)) ? 0 : ev_a[c][b];
        if (s[c*16+b]) begin
          if (base >= 255) m_ovf_a[c] = 1'b1;
          base++;
        end
        ev_a[c][b] = base;
        if (c < 3) begin
          base = (ca || (rq && rc && vb && int'(ch) == c && int'(idx) == b)) ? 0 : ev_b[c][b];
          if (s[c*16+b]) begin
            if (base % 256 == 255) m_ovf_b[c] = 1'b1;
            base++;
          end
          ev_b[c][b] = base;
        end
      end
    end
  endtask

  task automatic step(input logic r, input logic [63:0] s, input logic ca, input logic rq,
                      input logic [1:0] ch, input logic [3:0] idx, input logic rc);
    @(negedge clk);
    rst = r; status_in = s; clear_all = ca; rd_req = rq;
    rd_channel = ch; rd_index = idx; rd_clear = rc;
    model_edge(r, s, ca, rq, ch, idx, rc);
    @(posedge clk);
    #1;
    check("sat_ack",   64'(a_ack),  64'(m_ack));
    check("sat_data",  64'(a_data), 64'(m_data_a));
    check("sat_ovf",   64'(a_ovf),  64'(m_ovf_a));
    check("wrap_ack",  64'(b_ack),  64'(m_ack));
    check("wrap_data", 64'(b_data), 64'(m_data_b));
    check("wrap_ovf",  64'(b_ovf),  64'(m_ovf_b));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0);
  endtask

  task automatic rd(input int ch, input int idx, input logic clr);
    step(1'b0, '0, 1'b0, 1'b1, 2'(ch), 4'(idx), clr);
  endtask

  task automatic pulse(input int ch, input int bit_i, input int n);
    logic [63:0] v;
    v = '0;
    v[ch*16+bit_i] = 1'b1;
    for (int i = 0; i < n; i++) step(1'b0, v, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0);
  endtask

  initial begin
    logic [63:0] v;

    // Reset with every status bit high, then an idle read.
    step(1'b1, '1, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0);
    step(1'b1, '1, 1'b0, 1'b1, 2'd0, 4'd0, 1'b0);
    rd(0, 0, 1'b0);
    idle(1);

    // Basic counting and neighbour isolation.
    pulse(2, 5, 10);
    rd(2, 5, 1'b0); rd(2, 4, 1'b0); rd(1, 5, 1'b0);
    idle(1);

    // Clear-on-read with a coincident pulse.
    pulse(1, 2, 7);
    v = '0; v[1*16+2] = 1'b1;
    step(1'b0, v, 1'b0, 1'b1, 2'd1, 4'd2, 1'b1);
    rd(1, 2, 1'b0);

    // Saturation / wrap past the 8-bit limit, then clear_all.
    pulse(1, 3, 300);
    rd(1, 3, 1'b0);
    rd(1, 3, 1'b1);
    idle(2);
    step(1'b0, '0, 1'b1, 1'b1, 2'd2, 4'd5, 1'b0);
    rd(1, 3, 1'b0);
    pulse(0, 0, 257);
    rd(0, 0, 1'b0);
    // clear_all with a pulse in the same cycle leaves the counter at 1.
    v = '0; v[0] = 1'b1;
    step(1'b0, v, 1'b1, 1'b0, 2'd0, 4'd0, 1'b0);
    rd(0, 0, 1'b0);

    // Masked bit and out-of-range channel (for the 3-channel instance).
    pulse(0, 12, 5);
    rd(0, 12, 1'b0);
    pulse(3, 0, 4);
    rd(3, 0, 1'b1);
    rd(3, 0, 1'b0);

    // Back-to-back reads, then reset concurrent with a read.
    pulse(2, 6, 3);
    pulse(2, 7, 2);
    rd(2, 5, 1'b0); rd(2, 6, 1'b0); rd(2, 7, 1'b0); rd(2, 8, 1'b0);
    rd(2, 6, 1'b0);
    step(1'b1, '0, 1'b0, 1'b1, 2'd2, 4'd6, 1'b0);
    rd(2, 6, 1'b0); rd(2, 7, 1'b0);
    idle(1);

    // Randomised traffic.
    for (int i = 0; i < 4000; i++) begin
      logic [63:0] s;
      s = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
      step(($urandom_range(0, 999) == 0),
           s,
           ($urandom_range(0, 799) == 0),
           1'($urandom_range(0, 1)),
           2'($urandom),
           4'($urandom),
           ($urandom_range(0, 3) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
